// File: rtl/chip8_keypad.sv
// Chip-8 keyboard front end: PS/2 event decode, hex matrix, hotkeys, soft-reset stretch, FX0A wait FSM.
// Define KEYPAD_ARROWS_EN to alias the extended arrow keys onto hex keys 2/4/6/8.
module chip8_keypad #(
    parameter int LAYOUT          = 0,
    parameter int RESET_CYCLES    = 32,
    parameter int WAIT_ON_RELEASE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output logic [15:0] key_matrix,
    output logic        any_key,
    input  logic        wait_req,
    output logic        wait_ack,
    output logic [3:0]  wait_key,
    output logic        soft_reset,
    output logic        hard_reset_key,
    output logic        color_sel,
    output logic        video_mode_key
);

    typedef enum logic [1:0] {IDLE, ARMED, HELD, DONE} wait_state_e;

    localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES);

    logic        tog_q;
    logic [15:0] matrix_q, matrix_d;
    logic        ctrl_q, ctrl_d, alt_q, alt_d;
    logic        comboHard_q, comboHard_d, comboSoft_q, comboSoft_d;
    logic        f11_q, f11_d, f12_q, f12_d, f10_q, f10_d, scroll_q, scroll_d;
    logic [7:0]  cnt_q, cnt_d;
    wait_state_e state_q, state_d;
    logic        ack_q, ack_d;
    logic [3:0]  waitKey_q, waitKey_d;

    logic        evt, plainEvt, pressed, ext;
    logic [7:0]  code;
    logic        hexValid;
    logic [3:0]  hexIdx;
    logic        newPress, loadCnt;

    assign evt      = (ps2_key[10] != tog_q);
    assign pressed  = ps2_key[9];
    assign ext      = ps2_key[8];
    assign code     = ps2_key[7:0];
    assign plainEvt = evt && !ext;

    // Scancode (set 2) to hex key translation for the selected layout.
    always_comb begin
        hexValid = 1'b0;
        hexIdx   = 4'h0;
        if (!ext) begin
            if (LAYOUT == 0) begin
                hexValid = 1'b1;
                case (code)
                    8'h16: hexIdx = 4'h1;
                    8'h1E: hexIdx = 4'h2;
                    8'h26: hexIdx = 4'h3;
                    8'h25: hexIdx = 4'hC;
                    8'h15: hexIdx = 4'h4;
                    8'h1D: hexIdx = 4'h5;
                    8'h24: hexIdx = 4'h6;
                    8'h2D: hexIdx = 4'hD;
                    8'h1C: hexIdx = 4'h7;
                    8'h1B: hexIdx = 4'h8;
                    8'h23: hexIdx = 4'h9;
                    8'h2B: hexIdx = 4'hE;
                    8'h1A: hexIdx = 4'hA;
                    8'h22: hexIdx = 4'h0;
                    8'h21: hexIdx = 4'hB;
                    8'h2A: hexIdx = 4'hF;
                    default: hexValid = 1'b0;
                endcase
            end else begin
                hexValid = 1'b1;
                case (code)
                    8'h45: hexIdx = 4'h0;
                    8'h16: hexIdx = 4'h1;
                    8'h1E: hexIdx = 4'h2;
                    8'h26: hexIdx = 4'h3;
                    8'h25: hexIdx = 4'h4;
                    8'h2E: hexIdx = 4'h5;
                    8'h36: hexIdx = 4'h6;
                    8'h3D: hexIdx = 4'h7;
                    8'h3E: hexIdx = 4'h8;
                    8'h46: hexIdx = 4'h9;
                    8'h1C: hexIdx = 4'hA;
                    8'h32: hexIdx = 4'hB;
                    8'h21: hexIdx = 4'hC;
                    8'h23: hexIdx = 4'hD;
                    8'h24: hexIdx = 4'hE;
                    8'h2B: hexIdx = 4'hF;
                    default: hexValid = 1'b0;
                endcase
            end
        end
`ifdef KEYPAD_ARROWS_EN
        else begin
            hexValid = 1'b1;
            case (code)
                8'h75: hexIdx = 4'h2;
                8'h6B: hexIdx = 4'h4;
                8'h74: hexIdx = 4'h6;
                8'h72: hexIdx = 4'h8;
                default: hexValid = 1'b0;
            endcase
        end
`endif
    end

    always_comb begin
        matrix_d    = matrix_q;
        ctrl_d      = ctrl_q;
        alt_d       = alt_q;
        comboHard_d = comboHard_q;
        comboSoft_d = comboSoft_q;
        f11_d       = f11_q;
        f12_d       = f12_q;
        f10_d       = f10_q;
        scroll_d    = scroll_q;
        loadCnt     = 1'b0;
        if (evt && hexValid) begin
            matrix_d[hexIdx] = pressed;
        end
        if (plainEvt) begin
            case (code)
                8'h14: ctrl_d   = pressed;
                8'h11: alt_d    = pressed;
                8'h78: f11_d    = pressed;
                8'h09: f10_d    = pressed;
                8'h7E: scroll_d = pressed;
                8'h66: comboHard_d = pressed && ctrl_q && alt_q;
                8'h07: begin
                    f12_d   = pressed;
                    loadCnt = !pressed;
                end
                8'h71: begin
                    comboSoft_d = pressed && ctrl_q && alt_q;
                    loadCnt     = !pressed && comboSoft_q;
                end
                default: ;
            endcase
        end
        if (loadCnt) begin
            cnt_d = RESET_LOAD;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // A press only arms FX0A when the key was not already down, so held keys and typematic repeats are ignored.
    assign newPress = evt && hexValid && pressed && !matrix_q[hexIdx];

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        waitKey_d = waitKey_q;
        case (state_q)
            IDLE: begin
                if (wait_req) state_d = ARMED;
            end
            ARMED: begin
                if (!wait_req) begin
                    state_d = IDLE;
                end else if (newPress) begin
                    waitKey_d = hexIdx;
                    if (WAIT_ON_RELEASE == 0) begin
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!wait_req) begin
                    state_d = IDLE;
                end else if (evt && hexValid && !pressed && hexIdx == waitKey_q) begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!wait_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reloading tog_q from the live toggle bit on reset swallows any event coinciding with reset.
    always_ff @(posedge clk) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            matrix_q    <= 16'h0000;
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            comboHard_q <= 1'b0;
            comboSoft_q <= 1'b0;
            f11_q       <= 1'b0;
            f12_q       <= 1'b0;
            f10_q       <= 1'b0;
            scroll_q    <= 1'b0;
            cnt_q       <= 8'd0;
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            waitKey_q   <= 4'h0;
        end else begin
            matrix_q    <= matrix_d;
            ctrl_q      <= ctrl_d;
            alt_q       <= alt_d;
            comboHard_q <= comboHard_d;
            comboSoft_q <= comboSoft_d;
            f11_q       <= f11_d;
            f12_q       <= f12_d;
            f10_q       <= f10_d;
            scroll_q    <= scroll_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            ack_q       <= ack_d;
            waitKey_q   <= waitKey_d;
        end
    end

    assign key_matrix     = matrix_q;
    assign any_key        = |matrix_q;
    assign wait_ack       = ack_q;
    assign wait_key       = waitKey_q;
    assign soft_reset     = f12_q | comboSoft_q | (cnt_q != 8'd0);
    assign hard_reset_key = f11_q | comboHard_q;
    assign color_sel      = f10_q;
    assign video_mode_key = scroll_q;

endmodule

// File: tb/tb_chip8_keypad.sv
// Directed self-checking bench for chip8_keypad: QWERTY/default instance plus a hex-layout, ack-on-press instance.
module tb_chip8_keypad;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2Key, ps2Key1;
    logic        waitReq, waitReq1;
    logic [15:0] keyMatrix, keyMatrix1;
    logic        anyKey, anyKey1;
    logic        waitAck, waitAck1;
    logic [3:0]  waitKey, waitKey1;
    logic        softReset, softReset1;
    logic        hardReset, hardReset1;
    logic        colorSel, colorSel1;
    logic        videoMode, videoMode1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chip8_keypad dut (
        .clk(clk), .reset(reset), .ps2_key(ps2Key),
        .key_matrix(keyMatrix), .any_key(anyKey),
        .wait_req(waitReq), .wait_ack(waitAck), .wait_key(waitKey),
        .soft_reset(softReset), .hard_reset_key(hardReset),
        .color_sel(colorSel), .video_mode_key(videoMode)
    );

    chip8_keypad #(.LAYOUT(1), .RESET_CYCLES(3), .WAIT_ON_RELEASE(0)) dut1 (
        .clk(clk), .reset(reset), .ps2_key(ps2Key1),
        .key_matrix(keyMatrix1), .any_key(anyKey1),
        .wait_req(waitReq1), .wait_ack(waitAck1), .wait_key(waitKey1),
        .soft_reset(softReset1), .hard_reset_key(hardReset1),
        .color_sel(colorSel1), .video_mode_key(videoMode1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendKey(input logic pressed, input logic ext, input logic [7:0] code);
        ps2Key = {~ps2Key[10], pressed, ext, code};
    endtask

    task automatic sendKey1(input logic pressed, input logic ext, input logic [7:0] code);
        ps2Key1 = {~ps2Key1[10], pressed, ext, code};
    endtask

    task automatic test_reset();
        checks++; if (keyMatrix !== 16'h0000) begin errors++; $display("[TB] FAIL reset_matrix: got %h expected 0000", keyMatrix); end
        checks++; if (anyKey !== 1'b0) begin errors++; $display("[TB] FAIL reset_any_key: got %b expected 0", anyKey); end
        checks++; if (waitAck !== 1'b0 || waitKey !== 4'h0) begin errors++; $display("[TB] FAIL reset_wait: ack %b key %h expected 0 0", waitAck, waitKey); end
        checks++; if ({softReset, hardReset, colorSel, videoMode} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_hotkeys: got %b expected 0000", {softReset, hardReset, colorSel, videoMode}); end
        checks++; if (keyMatrix1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_matrix1: got %h expected 0000", keyMatrix1); end
    endtask

    task automatic test_layout0();
        sendKey(1'b1, 1'b0, 8'h15); tick();
        checks++; if (keyMatrix !== 16'h0010 || anyKey !== 1'b1) begin errors++; $display("[TB] FAIL l0_press_q: got %h any %b expected 0010 1", keyMatrix, anyKey); end
        sendKey(1'b0, 1'b0, 8'h15); tick();
        checks++; if (keyMatrix !== 16'h0000 || anyKey !== 1'b0) begin errors++; $display("[TB] FAIL l0_release_q: got %h any %b expected 0000 0", keyMatrix, anyKey); end
        sendKey(1'b1, 1'b0, 8'h2A); tick();
        checks++; if (keyMatrix !== 16'h8000) begin errors++; $display("[TB] FAIL l0_press_v: got %h expected 8000", keyMatrix); end
        sendKey(1'b1, 1'b0, 8'h22); tick();
        checks++; if (keyMatrix !== 16'h8001) begin errors++; $display("[TB] FAIL l0_press_x: got %h expected 8001", keyMatrix); end
        sendKey(1'b1, 1'b0, 8'h45); tick();
        checks++; if (keyMatrix !== 16'h8001) begin errors++; $display("[TB] FAIL l0_unmapped: got %h expected 8001", keyMatrix); end
        sendKey(1'b0, 1'b0, 8'h2A); tick();
        sendKey(1'b0, 1'b0, 8'h22); tick();
        checks++; if (keyMatrix !== 16'h0000) begin errors++; $display("[TB] FAIL l0_release_all: got %h expected 0000", keyMatrix); end
    endtask

    task automatic test_layout1();
        sendKey1(1'b1, 1'b0, 8'h1C); tick();
        checks++; if (keyMatrix1 !== 16'h0400) begin errors++; $display("[TB] FAIL l1_press_a: got %h expected 0400", keyMatrix1); end
        sendKey1(1'b1, 1'b0, 8'h15); tick();
        checks++; if (keyMatrix1 !== 16'h0400) begin errors++; $display("[TB] FAIL l1_press_q_ignored: got %h expected 0400", keyMatrix1); end
        sendKey1(1'b1, 1'b0, 8'h45); tick();
        checks++; if (keyMatrix1 !== 16'h0401) begin errors++; $display("[TB] FAIL l1_press_0: got %h expected 0401", keyMatrix1); end
        sendKey1(1'b0, 1'b0, 8'h1C); tick();
        sendKey1(1'b0, 1'b0, 8'h45); tick();
        checks++; if (keyMatrix1 !== 16'h0000 || anyKey1 !== 1'b0) begin errors++; $display("[TB] FAIL l1_release_all: got %h any %b expected 0000 0", keyMatrix1, anyKey1); end
    endtask

    task automatic test_back_to_back();
        sendKey(1'b1, 1'b0, 8'h16); tick();
        sendKey(1'b1, 1'b0, 8'h1E); tick();
        sendKey(1'b1, 1'b0, 8'h26); tick();
        checks++; if (keyMatrix !== 16'h000E) begin errors++; $display("[TB] FAIL b2b_press: got %h expected 000E", keyMatrix); end
        sendKey(1'b0, 1'b0, 8'h1E); tick();
        checks++; if (keyMatrix !== 16'h000A) begin errors++; $display("[TB] FAIL b2b_release_one: got %h expected 000A", keyMatrix); end
        sendKey(1'b0, 1'b0, 8'h16); tick();
        sendKey(1'b0, 1'b0, 8'h26); tick();
        checks++; if (keyMatrix !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_release: got %h expected 0000", keyMatrix); end
    endtask

    task automatic test_hotkeys();
        int n;
        sendKey(1'b1, 1'b0, 8'h78); tick();
        checks++; if (hardReset !== 1'b1) begin errors++; $display("[TB] FAIL f11_press: got %b expected 1", hardReset); end
        sendKey(1'b0, 1'b0, 8'h78); tick();
        checks++; if (hardReset !== 1'b0) begin errors++; $display("[TB] FAIL f11_release: got %b expected 0", hardReset); end
        sendKey(1'b1, 1'b1, 8'h78); tick();
        checks++; if (hardReset !== 1'b0) begin errors++; $display("[TB] FAIL f11_extended_ignored: got %b expected 0", hardReset); end
        sendKey(1'b0, 1'b1, 8'h78); tick();
        sendKey(1'b1, 1'b0, 8'h09); tick();
        sendKey(1'b1, 1'b0, 8'h7E); tick();
        checks++; if (colorSel !== 1'b1 || videoMode !== 1'b1) begin errors++; $display("[TB] FAIL f10_scroll_press: got %b %b expected 1 1", colorSel, videoMode); end
        sendKey(1'b0, 1'b0, 8'h09); tick();
        sendKey(1'b0, 1'b0, 8'h7E); tick();
        checks++; if (colorSel !== 1'b0 || videoMode !== 1'b0) begin errors++; $display("[TB] FAIL f10_scroll_release: got %b %b expected 0 0", colorSel, videoMode); end
        sendKey(1'b1, 1'b0, 8'h07); tick();
        checks++; if (softReset !== 1'b1) begin errors++; $display("[TB] FAIL f12_press: got %b expected 1", softReset); end
        sendKey(1'b0, 1'b0, 8'h07); tick();
        repeat (10) tick();
        checks++; if (softReset !== 1'b1) begin errors++; $display("[TB] FAIL f12_stretch_mid: got %b expected 1", softReset); end
        sendKey(1'b1, 1'b0, 8'h07); tick();
        checks++; if (softReset !== 1'b1) begin errors++; $display("[TB] FAIL f12_repress: got %b expected 1", softReset); end
        sendKey(1'b0, 1'b0, 8'h07); tick();
        n = 0;
        while (softReset === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (n !== 32) begin errors++; $display("[TB] FAIL f12_stretch_len: got %0d cycles expected 32", n); end
        sendKey1(1'b1, 1'b0, 8'h07); tick();
        sendKey1(1'b0, 1'b0, 8'h07); tick();
        n = 0;
        while (softReset1 === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL f12_stretch_len_dut1: got %0d cycles expected 3", n); end
    endtask

    task automatic test_combo();
        int n;
        sendKey(1'b1, 1'b0, 8'h71); tick();
        checks++; if (softReset !== 1'b0) begin errors++; $display("[TB] FAIL combo_no_mods: got %b expected 0", softReset); end
        sendKey(1'b0, 1'b0, 8'h71); tick(); tick();
        checks++; if (softReset !== 1'b0) begin errors++; $display("[TB] FAIL combo_no_mods_release: got %b expected 0", softReset); end
        sendKey(1'b1, 1'b0, 8'h14); tick();
        sendKey(1'b1, 1'b0, 8'h11); tick();
        sendKey(1'b1, 1'b0, 8'h66); tick();
        checks++; if (hardReset !== 1'b1) begin errors++; $display("[TB] FAIL cab_press: got %b expected 1", hardReset); end
        sendKey(1'b0, 1'b0, 8'h66); tick();
        checks++; if (hardReset !== 1'b0) begin errors++; $display("[TB] FAIL cab_release: got %b expected 0", hardReset); end
        sendKey(1'b1, 1'b0, 8'h71); tick();
        checks++; if (softReset !== 1'b1) begin errors++; $display("[TB] FAIL cad_press: got %b expected 1", softReset); end
        sendKey(1'b0, 1'b0, 8'h71); tick();
        n = 0;
        while (softReset === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (n !== 32) begin errors++; $display("[TB] FAIL cad_stretch_len: got %0d cycles expected 32", n); end
        sendKey(1'b0, 1'b0, 8'h11); tick();
        sendKey(1'b0, 1'b0, 8'h14); tick();
    endtask

    task automatic test_wait_release();
        sendKey(1'b1, 1'b0, 8'h1D); tick();
        waitReq = 1'b1; tick(); tick();
        checks++; if (waitAck !== 1'b0) begin errors++; $display("[TB] FAIL wait_held_ignored: got %b expected 0", waitAck); end
        sendKey(1'b1, 1'b0, 8'h23); tick();
        checks++; if (waitAck !== 1'b0) begin errors++; $display("[TB] FAIL wait_press_no_ack: got %b expected 0", waitAck); end
        sendKey(1'b0, 1'b0, 8'h1D); tick();
        checks++; if (waitAck !== 1'b0) begin errors++; $display("[TB] FAIL wait_other_release: got %b expected 0", waitAck); end
        sendKey(1'b0, 1'b0, 8'h23); tick();
        checks++; if (waitAck !== 1'b1 || waitKey !== 4'h9) begin errors++; $display("[TB] FAIL wait_ack_release: ack %b key %h expected 1 9", waitAck, waitKey); end
        tick();
        checks++; if (waitAck !== 1'b0 || waitKey !== 4'h9) begin errors++; $display("[TB] FAIL wait_ack_single: ack %b key %h expected 0 9", waitAck, waitKey); end
        waitReq = 1'b0; tick();
        waitReq = 1'b1; tick();
        sendKey(1'b1, 1'b0, 8'h16); tick();
        sendKey(1'b0, 1'b0, 8'h16); tick();
        checks++; if (waitAck !== 1'b1 || waitKey !== 4'h1) begin errors++; $display("[TB] FAIL wait_rearm: ack %b key %h expected 1 1", waitAck, waitKey); end
        waitReq = 1'b0; tick();
    endtask

    task automatic test_wait_press();
        waitReq1 = 1'b1; tick();
        sendKey1(1'b1, 1'b0, 8'h46); tick();
        checks++; if (waitAck1 !== 1'b1 || waitKey1 !== 4'h9) begin errors++; $display("[TB] FAIL wait_on_press: ack %b key %h expected 1 9", waitAck1, waitKey1); end
        tick();
        checks++; if (waitAck1 !== 1'b0) begin errors++; $display("[TB] FAIL wait_on_press_single: got %b expected 0", waitAck1); end
        sendKey1(1'b0, 1'b0, 8'h46); tick();
        checks++; if (waitAck1 !== 1'b0) begin errors++; $display("[TB] FAIL wait_on_press_release: got %b expected 0", waitAck1); end
        waitReq1 = 1'b0; tick();
    endtask

    task automatic test_arrows();
        logic [15:0] expUp;
`ifdef KEYPAD_ARROWS_EN
        expUp = 16'h0004;
`else
        expUp = 16'h0000;
`endif
        sendKey(1'b1, 1'b1, 8'h75); tick();
        checks++; if (keyMatrix !== expUp) begin errors++; $display("[TB] FAIL arrow_up_press: got %h expected %h", keyMatrix, expUp); end
        sendKey(1'b0, 1'b1, 8'h75); tick();
        checks++; if (keyMatrix !== 16'h0000) begin errors++; $display("[TB] FAIL arrow_up_release: got %h expected 0000", keyMatrix); end
    endtask

    task automatic test_reset_mid_wait();
        waitReq = 1'b1; tick();
        sendKey(1'b1, 1'b0, 8'h16); tick();
        checks++; if (keyMatrix !== 16'h0002 || waitAck !== 1'b0) begin errors++; $display("[TB] FAIL rmw_held: got %h ack %b expected 0002 0", keyMatrix, waitAck); end
        reset = 1'b1;
        sendKey(1'b1, 1'b0, 8'h1E); tick();
        checks++; if (keyMatrix !== 16'h0000 || waitAck !== 1'b0 || waitKey !== 4'h0) begin errors++; $display("[TB] FAIL rmw_reset: got %h ack %b key %h expected 0000 0 0", keyMatrix, waitAck, waitKey); end
        reset = 1'b0; tick();
        checks++; if (keyMatrix !== 16'h0000 || waitAck !== 1'b0) begin errors++; $display("[TB] FAIL rmw_no_spurious: got %h ack %b expected 0000 0", keyMatrix, waitAck); end
        sendKey(1'b0, 1'b0, 8'h16); tick();
        checks++; if (waitAck !== 1'b0) begin errors++; $display("[TB] FAIL rmw_aborted: got %b expected 0", waitAck); end
        waitReq = 1'b0; tick();
    endtask

    initial begin
        reset    = 1'b1;
        ps2Key   = 11'h000;
        ps2Key1  = 11'h000;
        waitReq  = 1'b0;
        waitReq1 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_layout0();
        test_layout1();
        test_back_to_back();
        test_hotkeys();
        test_combo();
        test_wait_release();
        test_wait_press();
        test_arrows();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
